mod_enc_sb_collect: RTL and testbench

- Downstream neighbour of the encryption S-box ROM stage (mod_enc_rom256).
- Accepts substituted bytes presented by the ROM via wr_req/data and assembles them into complete 128-bit AES states.
- Buffers up to two complete states in ping-pong banks for the ShiftRows stage.
- Drives fifo_full back to the ROM stage as its only backpressure.

---
 rtl/mod_enc_sb_collect.sv | 129 ++++++++++++
 tb/tb_mod_enc_sb_collect.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mod_enc_sb_collect.sv
`default_nettype none
// ============================================================================
// Module  : mod_enc_sb_collect
// Purpose : Collects S-box output bytes into 128-bit states, double-buffered.
// Rev     : 1.0  initial release
// ============================================================================
module mod_enc_sb_collect #(
    parameter int NBYTES = 16,
    parameter int BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic [BYTE_W-1:0]        data_in,
    input  logic                     flush,
    input  logic                     rd_req,
    output logic                     fifo_full,
    output logic                     out_valid,
    output logic [NBYTES*BYTE_W-1:0] state_out,
    output logic                     blk_done,
    output logic                     ovf_err
);

    localparam int C_SW = NBYTES * BYTE_W;
    localparam int C_CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [C_CW-1:0]     r_cnt;
    logic [C_CW-1:0]     w_cnt_n;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                w_wr_bank_n;
    logic                w_rd_bank_n;
    logic [1:0]          r_valid;
    logic [1:0]          w_valid_n;
    logic [1:0][C_SW-1:0] r_bank;
    logic [1:0][C_SW-1:0] w_bank_n;
    logic [C_SW-1:0]     r_state_out;
    logic [C_SW-1:0]     w_state_out_n;
    logic                r_blk_done;
    logic                r_ovf_err;
    logic                w_pop;
    logic                w_accept;
    logic                w_reject;
    logic                w_complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_valid     <= 2'b00;
            r_bank      <= '0;
            r_state_out <= '0;
            r_blk_done  <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_wr_bank   <= w_wr_bank_n;
            r_rd_bank   <= w_rd_bank_n;
            r_valid     <= w_valid_n;
            r_bank      <= w_bank_n;
            r_state_out <= w_state_out_n;
            r_blk_done  <= w_complete;
            r_ovf_err   <= r_ovf_err | w_reject;
        end
    end

    // Acceptance is decided purely from registered state (STALL == both banks full),
    // so a same-cycle pop never rescues a write aimed at a full buffer.
    always_comb begin
        w_pop      = rd_req & r_valid[r_rd_bank];
        w_accept   = wr_req & ~flush & (r_state == FILL);
        w_reject   = wr_req & ~flush & (r_state == STALL);
        w_complete = w_accept & (r_cnt == C_CW'(NBYTES - 1));

        w_bank_n = r_bank;
        if (w_accept) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (r_cnt == C_CW'(k)) begin
                    w_bank_n[r_wr_bank][(NBYTES-1-k)*BYTE_W +: BYTE_W] = data_in;
                end
            end
        end

        w_cnt_n = r_cnt;
        if (flush) begin
            w_cnt_n = '0;
        end else if (w_accept) begin
            w_cnt_n = w_complete ? '0 : r_cnt + 1'b1;
        end

        w_valid_n = r_valid;
        if (w_pop) begin
            w_valid_n[r_rd_bank] = 1'b0;
        end
        if (w_complete) begin
            w_valid_n[r_wr_bank] = 1'b1;
        end

        w_wr_bank_n = r_wr_bank ^ w_complete;
        w_rd_bank_n = r_rd_bank ^ w_pop;

        // Follow the bank that will be current after the edge, including a byte
        // that completes it this very cycle; otherwise hold the last value shown.
        w_state_out_n = r_state_out;
        if (w_valid_n[w_rd_bank_n]) begin
            w_state_out_n = w_bank_n[w_rd_bank_n];
        end

        w_state_n = (w_valid_n == 2'b11) ? STALL : FILL;
    end

    assign fifo_full = r_valid[0] & r_valid[1];
    assign out_valid = r_valid[r_rd_bank];
    assign state_out = r_state_out;
    assign blk_done  = r_blk_done;
    assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_enc_sb_collect.sv
`default_nettype none
// Directed, table-driven bench for mod_enc_sb_collect plus a hand-written async reset sequence.
module tb_mod_enc_sb_collect;

    logic         clk;
    logic         rst;
    logic         wr_req;
    logic [7:0]   data_in;
    logic         flush;
    logic         rd_req;
    logic         fifo_full;
    logic         out_valid;
    logic [127:0] state_out;
    logic         blk_done;
    logic         ovf_err;

    mod_enc_sb_collect #(.NBYTES(16), .BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .data_in   (data_in),
        .flush     (flush),
        .rd_req    (rd_req),
        .fifo_full (fifo_full),
        .out_valid (out_valid),
        .state_out (state_out),
        .blk_done  (blk_done),
        .ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [7:0]   d;
        logic         rd;
        logic         fl;
        logic         e_full;
        logic         e_val;
        logic         e_done;
        logic         e_ovf;
        logic         chk;
        logic [127:0] e_state;
    } vec_t;

    vec_t tbl [0:255];
    int   nvec  = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [127:0] blk(input logic [7:0] start);
        logic [127:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) s = {s[119:0], start + 8'(i)};
        return s;
    endfunction

    task automatic add(input logic wr, input logic [7:0] d, input logic rd, input logic fl,
                       input logic ef, input logic ev, input logic ed, input logic eo,
                       input logic chk, input logic [127:0] es);
        tbl[nvec] = '{wr, d, rd, fl, ef, ev, ed, eo, chk, es};
        nvec++;
    endtask

    task automatic cmp1(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    task automatic cmps(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic ef, input logic ev,
                             input logic ed, input logic eo, input logic chk, input logic [127:0] es);
        cmp1({tag, "_full"}, idx, fifo_full, ef);
        cmp1({tag, "_valid"}, idx, out_valid, ev);
        cmp1({tag, "_done"}, idx, blk_done, ed);
        cmp1({tag, "_ovf"}, idx, ovf_err, eo);
        if (chk) cmps({tag, "_state"}, idx, state_out, es);
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
        wr_req = wr; data_in = d; rd_req = rd; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b0; data_in = 8'h00; flush = 1'b0; rd_req = 1'b0;

        // A: single block 00..0F, then pop to empty
        for (int i = 0; i < 15; i++) add(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, '0);
        add(1, 8'h0F, 0, 0, 0, 1, 1, 0, 1, blk(8'h00));
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, blk(8'h00));
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, blk(8'h00));
        // B: partial 5 bytes, flush with a colliding write, then clean block 20..2F
        for (int i = 0; i < 5; i++) add(1, 8'h50 + 8'(i), 0, 0, 0, 0, 0, 0, 1, blk(8'h00));
        add(1, 8'h99, 0, 1, 0, 0, 0, 0, 1, blk(8'h00));
        for (int i = 0; i < 15; i++) add(1, 8'h20 + 8'(i), 0, 0, 0, 0, 0, 0, 0, '0);
        add(1, 8'h2F, 0, 0, 0, 1, 1, 0, 1, blk(8'h20));
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, blk(8'h20));
        // C: pops while empty are ignored; next block still lands correctly
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, blk(8'h20));
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, blk(8'h20));
        for (int i = 0; i < 15; i++) add(1, 8'h60 + 8'(i), 0, 0, 0, 0, 0, 0, 1, blk(8'h20));
        add(1, 8'h6F, 0, 0, 0, 1, 1, 0, 1, blk(8'h60));
        // D: completing write coincides with a pop of the only valid bank
        for (int i = 0; i < 15; i++) add(1, 8'h70 + 8'(i), 0, 0, 0, 1, 0, 0, 1, blk(8'h60));
        add(1, 8'h7F, 1, 0, 0, 1, 1, 0, 1, blk(8'h70));
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, blk(8'h70));
        // E: fill both banks, overflow, write+pop while full, then refill
        for (int i = 0; i < 15; i++) add(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, '0);
        add(1, 8'h0F, 0, 0, 0, 1, 1, 0, 1, blk(8'h00));
        for (int i = 16; i < 31; i++) add(1, 8'(i), 0, 0, 0, 1, 0, 0, 1, blk(8'h00));
        add(1, 8'h1F, 0, 0, 1, 1, 1, 0, 1, blk(8'h00));
        add(1, 8'hAA, 0, 0, 1, 1, 0, 1, 1, blk(8'h00));
        add(1, 8'hBB, 1, 0, 0, 1, 0, 1, 1, blk(8'h10));
        for (int i = 0; i < 15; i++) add(1, 8'hC0 + 8'(i), 0, 0, 0, 1, 0, 1, 1, blk(8'h10));
        add(1, 8'hCF, 0, 0, 1, 1, 1, 1, 1, blk(8'h10));
        add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1, blk(8'hC0));

        // reset state, sampled while reset is held
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("reset", -1, 0, 0, 0, 0, 1, '0);
        rst = 1'b0;

        for (int v = 0; v < nvec; v++) begin
            step(tbl[v].wr, tbl[v].d, tbl[v].rd, tbl[v].fl);
            check_all("vec", v, tbl[v].e_full, tbl[v].e_val, tbl[v].e_done, tbl[v].e_ovf,
                      tbl[v].chk, tbl[v].e_state);
        end

        // F: async reset between edges, 9 bytes into a block with one bank full
        for (int i = 0; i < 9; i++) step(1, 8'hD0 + 8'(i), 0, 0);
        wr_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", -2, 0, 0, 0, 0, 1, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step(1, 8'hE0 + 8'(i), 0, 0);
        check_all("post_rst_partial", -3, 0, 0, 0, 0, 1, '0);
        step(1, 8'hEF, 0, 0);
        check_all("post_rst_blk", -4, 0, 1, 1, 0, 1, blk(8'hE0));
        step(0, 8'h00, 1, 0);
        check_all("post_rst_pop", -5, 0, 0, 0, 0, 1, blk(8'hE0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
